// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the MIPS-subset core: sequences IF/ID/EX/MEM/WB,
// handles memory ready handshakes, branch/jump sequencing, illegal-op trapping and retire counting.
module multicycle_ctrl #(
    parameter int ALUOP_W   = 4,
    parameter int CNT_W     = 32,
    parameter bit BRANCH_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic [2:0]         state,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] aluop,
    output logic               s_num_write,
    output logic [1:0]         s_ext,
    output logic               s_b,
    output logic               s_data_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_JMP, C_ILL
    } class_t;

    localparam logic [1:0] EXTOP_ZEROEXTEND = 2'd0;
    localparam logic [1:0] EXTOP_SIGNEXTEND = 2'd1;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // ALU codes follow the low bits of the matching SPECIAL funct (ADDU=0x21, SUBU=0x23, ...).
    localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(4'h1);
    localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(4'h3);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4'h4);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'h5);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(4'hF);

    state_t              state_q;
    class_t              cls_q;

    class_t              dec_cls;
    logic [ALUOP_W-1:0]  dec_aluop;
    logic                dec_num_write;
    logic [1:0]          dec_ext;
    logic                dec_b;
    logic                dec_data_write;

    logic                unused_funct;
    assign unused_funct = ^funct;

    assign state = state_q;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        dec_cls        = C_ILL;
        dec_aluop      = '0;
        dec_num_write  = 1'b0;
        dec_ext        = EXTOP_ZEROEXTEND;
        dec_b          = 1'b0;
        dec_data_write = 1'b0;
        unique case (op)
            6'h00: begin
                dec_cls       = C_ALU;
                dec_aluop     = funct[ALUOP_W-1:0];
                dec_num_write = 1'b1;
            end
            6'h08, 6'h09: begin
                dec_cls   = C_ALU;
                dec_aluop = ALU_ADDU;
                dec_ext   = EXTOP_SIGNEXTEND;
                dec_b     = 1'b1;
            end
            6'h0C: begin
                dec_cls   = C_ALU;
                dec_aluop = ALU_AND;
                dec_b     = 1'b1;
            end
            6'h0D: begin
                dec_cls   = C_ALU;
                dec_aluop = ALU_OR;
                dec_b     = 1'b1;
            end
            6'h0F: begin
                dec_cls   = C_ALU;
                dec_aluop = ALU_LUI;
                dec_b     = 1'b1;
            end
            6'h23, 6'h2B: begin
                dec_cls        = (op == 6'h23) ? C_LW : C_SW;
                dec_aluop      = ALU_ADDU;
                dec_ext        = EXTOP_SIGNEXTEND;
                dec_b          = 1'b1;
                dec_data_write = (op == 6'h23);
            end
            6'h04, 6'h05: begin
                if (BRANCH_EN) begin
                    dec_cls   = (op == 6'h04) ? C_BEQ : C_BNE;
                    dec_aluop = ALU_SUBU;
                    dec_ext   = EXTOP_SIGNEXTEND;
                end
            end
            6'h02: begin
                if (BRANCH_EN) dec_cls = C_JMP;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IF;
            cls_q        <= C_ALU;
            aluop        <= '0;
            s_num_write  <= 1'b0;
            s_ext        <= EXTOP_ZEROEXTEND;
            s_b          <= 1'b0;
            s_data_write <= 1'b0;
            illegal      <= 1'b0;
            retired      <= '0;
        end else begin
            case (state_q)
                S_IF: begin
                    if (imem_ready) state_q <= S_ID;
                end
                S_ID: begin
                    if (dec_cls == C_ILL) begin
                        state_q <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        cls_q        <= dec_cls;
                        aluop        <= dec_aluop;
                        s_num_write  <= dec_num_write;
                        s_ext        <= dec_ext;
                        s_b          <= dec_b;
                        s_data_write <= dec_data_write;
                        if (dec_cls == C_JMP) begin
                            state_q <= S_IF;
                            retired <= retired + CNT_W'(1);
                        end else begin
                            state_q <= S_EX;
                        end
                    end
                end
                S_EX: begin
                    case (cls_q)
                        C_BEQ, C_BNE: begin
                            state_q <= S_IF;
                            retired <= retired + CNT_W'(1);
                        end
                        C_LW, C_SW: state_q <= S_MEM;
                        default:    state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls_q == C_SW) begin
                            state_q <= S_IF;
                            retired <= retired + CNT_W'(1);
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q <= S_IF;
                    retired <= retired + CNT_W'(1);
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_IF;
            endcase
        end
    end

    // Strobes are gated by rst so an abort drops them at once, not at the next edge.
    always_comb begin
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                end
                S_ID: begin
                    if (dec_cls == C_JMP) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                end
                S_EX: begin
                    if (cls_q == C_BEQ) begin
                        pc_write = zero;
                        pc_src   = PC_BRANCH;
                    end else if (cls_q == C_BNE) begin
                        pc_write = !zero;
                        pc_src   = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    mem_read  = (cls_q == C_LW);
                    mem_write = (cls_q == C_SW);
                end
                S_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
